// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB I2C master: base address,
// command/status field positions and the master FSM state enum.
package apb_i2c_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

  localparam int CMD_START  = 0;
  localparam int CMD_SRST   = 1;
  localparam int CMD_SPEED  = 2;
  localparam int CMD_RW     = 3;
  localparam int CMD_ADDR   = 4;
  localparam int CMD_WDATA  = 11;

  localparam int ST_RX      = 11;
  localparam int ST_DONE    = 19;
  localparam int ST_NACK    = 20;
  localparam int ST_BUSY    = 21;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_DACK,
    S_RDATA,
    S_MNACK,
    S_STOP,
    S_DONE
  } state_t;

endpackage

// File: rtl/apb_i2c_top_i2c_master_core.sv
// Single-byte I2C master: bit divider, FSM, shifter, SCL/SDA drive.
// Ports: clk/rst_n, start/soft_rst/fields in, sda_in, scl/sda_oe/flags out.
module i2c_master_core
  import apb_i2c_pkg::*;
#(
  parameter int FAST_DIV = 8,
  parameter int SLOW_DIV = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       soft_rst,
  input  logic       speed,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rx_byte
);

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [5:0]  div;
  logic [5:0]  half;
  logic [5:0]  quart;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  wd_q;
  logic        rw_q;
  logic        ack_bad;
  logic        in_bit;
  logic        bit_end;
  logic        q1;
  logic        q3;
  logic        restart;

  assign half    = {1'b0, div[5:1]};
  assign quart   = {2'b0, div[5:2]};
  assign bit_end = (cnt == div - 6'd1);
  assign q1      = (cnt == quart);
  assign q3      = (cnt == half + quart);

  assign in_bit = state inside {S_ADDR, S_AACK,
                                S_WDATA, S_DACK,
                                S_RDATA, S_MNACK};

  assign busy = (state != S_IDLE);

  // SCL low for the first half of every bit
  // slot and of the STOP slot, high otherwise.
  assign scl = (in_bit || state == S_STOP) ?
               (cnt >= half) : 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_START;
      S_START: if (cnt == half - 6'd1) state_nx = S_ADDR;
      S_ADDR:  if (bit_end && bit_idx == 3'd7)
                 state_nx = S_AACK;
      S_AACK:  if (bit_end)
                 state_nx = ack_bad ? S_STOP :
                            (rw_q ? S_RDATA : S_WDATA);
      S_WDATA: if (bit_end && bit_idx == 3'd7)
                 state_nx = S_DACK;
      S_DACK:  if (bit_end) state_nx = S_STOP;
      S_RDATA: if (bit_end && bit_idx == 3'd7)
                 state_nx = S_MNACK;
      S_MNACK: if (bit_end) state_nx = S_STOP;
      S_STOP:  if (cnt == div) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (soft_rst) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Counter restarts on every state change and
  // on every bit boundary inside a byte.
  assign restart = (state_nx != state) ||
                   (in_bit && bit_end) ||
                   (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n || soft_rst) begin
      cnt     <= '0;
      div     <= 6'(SLOW_DIV);
      bit_idx <= '0;
      shreg   <= '0;
      wd_q    <= '0;
      rw_q    <= 1'b0;
      ack_bad <= 1'b0;
      sda_oe  <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      rx_byte <= '0;
    end else begin
      cnt <= restart ? '0 : cnt + 6'd1;
      unique case (state)
        S_IDLE: if (start) begin
          div     <= speed ? 6'(FAST_DIV)
                           : 6'(SLOW_DIV);
          shreg   <= {addr, rw};
          wd_q    <= wdata;
          rw_q    <= rw;
          bit_idx <= '0;
          ack_bad <= 1'b0;
          done    <= 1'b0;
          nack    <= 1'b0;
          rx_byte <= '0;
          sda_oe  <= 1'b1;
        end
        S_ADDR, S_WDATA: begin
          if (q1) sda_oe <= ~shreg[7];
          if (bit_end) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_AACK, S_DACK: begin
          if (q1) sda_oe <= 1'b0;
          if (q3) begin
            ack_bad <= sda_in;
            if (sda_in) nack <= 1'b1;
          end
          if (bit_end) shreg <= wd_q;
        end
        S_RDATA: begin
          if (q1) sda_oe <= 1'b0;
          if (q3) rx_byte <= {rx_byte[6:0], sda_in};
          if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
        S_MNACK: begin
          if (q1) sda_oe <= 1'b0;
        end
        S_STOP: begin
          if (q1) sda_oe <= 1'b1;
          if (cnt == div) sda_oe <= 1'b0;
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/apb_i2c_top.sv
// APB slave front end of the I2C master: command decode, status mux.
// Ports: APB (PCLK/PRESETn/PADDR/PSELx/PENABLE/PWRITE/PWDATA/PRDATA), SDA, SCL.
module apb_i2c_top
  import apb_i2c_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          FAST_DIV  = 8,
  parameter int          SLOW_DIV  = 32
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  inout  wire         SDA,
  output logic        SCL
);

  logic       hit;
  logic       wr;
  logic       soft_rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       nack;
  logic       sda_oe;
  logic       sda_in;
  logic [7:0] rx_byte;
  logic [31:0] status;
  logic       unused_bits;

  assign hit      = (PADDR == BASE_ADDR);
  assign wr       = PSELx & PENABLE & PWRITE & hit;
  assign soft_rst = wr & PWDATA[CMD_SRST];
  assign start    = wr & PWDATA[CMD_START] &
                    ~PWDATA[CMD_SRST] & ~busy;

  assign unused_bits = ^PWDATA[31:19];

  assign SDA    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  always_comb begin
    status                = '0;
    status[ST_RX +: 8]    = rx_byte;
    status[ST_DONE]       = done;
    status[ST_NACK]       = nack;
    status[ST_BUSY]       = busy;
  end

  assign PRDATA = (PSELx & ~PWRITE & hit) ?
                  status : '0;

  i2c_master_core #(
    .FAST_DIV (FAST_DIV),
    .SLOW_DIV (SLOW_DIV)
  ) u_core (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .start    (start),
    .soft_rst (soft_rst),
    .speed    (PWDATA[CMD_SPEED]),
    .rw       (PWDATA[CMD_RW]),
    .addr     (PWDATA[CMD_ADDR +: 7]),
    .wdata    (PWDATA[CMD_WDATA +: 8]),
    .sda_in   (sda_in),
    .scl      (SCL),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .rx_byte  (rx_byte)
  );

endmodule

// File: tb/tb_apb_i2c_top.sv
// Bench for apb_i2c_top: APB driver, I2C slave model on SDA/SCL,
// and a scoreboard of expected per-transaction results.
`timescale 1ns/1ps
module tb_apb_i2c_top;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int P_IDLE  = 0;
  localparam int P_ADDR  = 1;
  localparam int P_AACK  = 2;
  localparam int P_RDATA = 3;
  localparam int P_WDATA = 4;
  localparam int P_DACK  = 5;

  typedef struct {
    logic [7:0]  abyte;
    logic [7:0]  dbyte;
    logic [31:0] status;
    int          rises;
    int          period;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        psel;
  logic        pen;
  logic        pwr;
  logic        scl;
  logic        slv_low;
  wire         sda;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #25 clk = ~clk;

  apb_i2c_top dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PADDR   (paddr),
    .PSELx   (psel),
    .PENABLE (pen),
    .PWRITE  (pwr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .SDA     (sda),
    .SCL     (scl)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  int starts = 0;
  int stops = 0;
  int rises = 0;
  int total_rises = 0;
  int period = 0;
  int bitcnt = 0;
  int rbit = 0;
  int phase = P_IDLE;
  time t_last = 0;
  logic [7:0] addr_cap = '0;
  logic [7:0] data_cap = '0;
  logic [7:0] tx_byte = 8'hC5;
  logic       ack_en = 1'b1;

  // I2C slave model, evaluated on the falling PCLK edge.
  initial begin
    logic pc, ps, c, s;
    pc = 1'b1;
    ps = 1'b1;
    slv_low = 1'b0;
    forever begin
      @(negedge clk);
      c = scl;
      s = sda;
      if (c && pc && ps && !s) begin
        starts++;
        phase = P_ADDR;
        bitcnt = 0;
        rises = 0;
        addr_cap = '0;
        data_cap = '0;
      end else if (c && pc && !ps && s) begin
        stops++;
        phase = P_IDLE;
      end else if (c && !pc) begin
        total_rises++;
        rises++;
        if (rises == 2) period = int'($time - t_last);
        t_last = $time;
        if (phase == P_ADDR && bitcnt < 8) begin
          addr_cap = {addr_cap[6:0], s};
          bitcnt++;
        end else if (phase == P_WDATA && bitcnt < 8) begin
          data_cap = {data_cap[6:0], s};
          bitcnt++;
        end
      end else if (!c && pc) begin
        case (phase)
          P_ADDR: if (bitcnt == 8) begin
            slv_low = ack_en;
            phase = P_AACK;
          end
          P_AACK: begin
            slv_low = 1'b0;
            if (!ack_en) phase = P_IDLE;
            else if (addr_cap[0]) begin
              slv_low = !tx_byte[7];
              rbit = 1;
              phase = P_RDATA;
            end else begin
              bitcnt = 0;
              phase = P_WDATA;
            end
          end
          P_RDATA: if (rbit < 8) begin
            slv_low = !tx_byte[7-rbit];
            rbit++;
          end else begin
            slv_low = 1'b0;
            phase = P_IDLE;
          end
          P_WDATA: if (bitcnt == 8) begin
            slv_low = ack_en;
            phase = P_DACK;
          end
          P_DACK: begin
            slv_low = 1'b0;
            phase = P_IDLE;
          end
          default: ;
        endcase
      end
      pc = c;
      ps = s;
    end
  end

  task automatic apb_wr(input logic [31:0] a,
                        input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwr = 1'b1; pen = 1'b0;
    paddr = a; pwdata = d;
    @(posedge clk); #1;
    pen = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0; pwr = 1'b0;
  endtask

  task automatic apb_rd(input  logic [31:0] a,
                        output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwr = 1'b0; pen = 1'b0;
    paddr = a;
    @(posedge clk); #1;
    pen = 1'b1;
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] st,
                           output logic ok);
    ok = 1'b0;
    st = '0;
    for (int i = 0; i < 3000; i++) begin
      apb_rd(BASE, st);
      if (st[19]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int target,
                            output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (total_rises >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    psel = 1'b0; pen = 1'b0; pwr = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if (scl !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_scl got=%b exp=1", scl);
    end
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sda got=%b exp=1", sda);
    end
    apb_rd(BASE, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_prdata got=%h exp=0", d);
    end
  endtask

  task automatic test_read_fast();
    logic [31:0] d;
    logic ok;
    exp_t e;
    int s0, p0;
    s0 = starts;
    p0 = stops;
    ack_en = 1'b1;
    tx_byte = 8'hC5;
    sb.push_back('{8'hC7, 8'h00, 32'h000E_2800, 19, 400});
    apb_wr(BASE, 32'h0000_063D);
    repeat (40) @(posedge clk);
    apb_rd(BASE, d);
    n_cmp++;
    if (d[21:19] !== 3'b100) begin
      n_bad++;
      $display("FAIL busy_poll got=%b exp=100", d[21:19]);
    end
    apb_wr(BASE, 32'h0000_0105);
    wait_done(d, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL read_timeout got=0 exp=1");
    end
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.status) begin
      n_bad++;
      $display("FAIL read_status got=%h exp=%h", d, e.status);
    end
    n_cmp++;
    if (addr_cap !== e.abyte) begin
      n_bad++;
      $display("FAIL read_abyte got=%h exp=%h", addr_cap, e.abyte);
    end
    n_cmp++;
    if (rises !== e.rises) begin
      n_bad++;
      $display("FAIL read_rises got=%0d exp=%0d", rises, e.rises);
    end
    n_cmp++;
    if (period !== e.period) begin
      n_bad++;
      $display("FAIL read_period got=%0d exp=%0d", period, e.period);
    end
    n_cmp++;
    if (starts - s0 !== 1) begin
      n_bad++;
      $display("FAIL busy_start got=%0d exp=1", starts - s0);
    end
    n_cmp++;
    if (stops - p0 !== 1) begin
      n_bad++;
      $display("FAIL read_stop got=%0d exp=1", stops - p0);
    end
  endtask

  task automatic test_write_slow();
    logic [31:0] d;
    logic ok;
    exp_t e;
    int p0;
    p0 = stops;
    ack_en = 1'b1;
    sb.push_back('{8'h42, 8'h5A, 32'h0008_0000, 19, 1600});
    apb_wr(BASE, 32'h0002_D211);
    wait_done(d, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL write_timeout got=0 exp=1");
    end
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.status) begin
      n_bad++;
      $display("FAIL write_status got=%h exp=%h", d, e.status);
    end
    n_cmp++;
    if (addr_cap !== e.abyte) begin
      n_bad++;
      $display("FAIL write_abyte got=%h exp=%h", addr_cap, e.abyte);
    end
    n_cmp++;
    if (data_cap !== e.dbyte) begin
      n_bad++;
      $display("FAIL write_dbyte got=%h exp=%h", data_cap, e.dbyte);
    end
    n_cmp++;
    if (period !== e.period) begin
      n_bad++;
      $display("FAIL write_period got=%0d exp=%0d", period, e.period);
    end
    n_cmp++;
    if (rises !== e.rises) begin
      n_bad++;
      $display("FAIL write_rises got=%0d exp=%0d", rises, e.rises);
    end
    n_cmp++;
    if (stops - p0 !== 1) begin
      n_bad++;
      $display("FAIL write_stop got=%0d exp=1", stops - p0);
    end
  endtask

  task automatic test_addr_nack();
    logic [31:0] d;
    logic ok;
    exp_t e;
    int p0;
    p0 = stops;
    ack_en = 1'b0;
    sb.push_back('{8'h42, 8'h00, 32'h0018_0000, 10, 400});
    apb_wr(BASE, 32'h0007_FA15);
    wait_done(d, ok);
    ack_en = 1'b1;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL nack_timeout got=0 exp=1");
    end
    e = sb.pop_front();
    n_cmp++;
    if (d !== e.status) begin
      n_bad++;
      $display("FAIL nack_status got=%h exp=%h", d, e.status);
    end
    n_cmp++;
    if (addr_cap !== e.abyte) begin
      n_bad++;
      $display("FAIL nack_abyte got=%h exp=%h", addr_cap, e.abyte);
    end
    n_cmp++;
    if (rises !== e.rises) begin
      n_bad++;
      $display("FAIL nack_rises got=%0d exp=%0d", rises, e.rises);
    end
    n_cmp++;
    if (stops - p0 !== 1) begin
      n_bad++;
      $display("FAIL nack_stop got=%0d exp=1", stops - p0);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    int r0;
    r0 = total_rises;
    apb_wr(32'h8000_0004, 32'h0000_063D);
    repeat (200) @(posedge clk);
    n_cmp++;
    if (total_rises !== r0) begin
      n_bad++;
      $display("FAIL badaddr_scl got=%0d exp=%0d", total_rises, r0);
    end
    apb_rd(32'h8000_0004, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL badaddr_rd got=%h exp=0", d);
    end
    apb_rd(BASE, d);
    n_cmp++;
    if (d[21] !== 1'b0) begin
      n_bad++;
      $display("FAIL badaddr_busy got=%b exp=0", d[21]);
    end
  endtask

  task automatic test_hard_reset();
    logic ok;
    int r0;
    apb_wr(BASE, 32'h0002_D211);
    wait_rises(total_rises + 3, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hrst_timeout got=0 exp=1");
    end
    psel = 1'b1; pwr = 1'b0; pen = 1'b1;
    paddr = BASE;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (scl !== 1'b1) begin
      n_bad++;
      $display("FAIL hrst_scl got=%b exp=1", scl);
    end
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL hrst_sda got=%b exp=1", sda);
    end
    n_cmp++;
    if (prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL hrst_prdata got=%h exp=0", prdata);
    end
    rst_n = 1'b1;
    psel = 1'b0; pen = 1'b0;
    r0 = total_rises;
    repeat (100) @(posedge clk);
    n_cmp++;
    if (total_rises !== r0) begin
      n_bad++;
      $display("FAIL hrst_idle got=%0d exp=%0d", total_rises, r0);
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d;
    logic ok;
    apb_wr(BASE, 32'h0002_D211);
    wait_rises(total_rises + 4, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL srst_timeout got=0 exp=1");
    end
    apb_wr(BASE, 32'h0000_0002);
    n_cmp++;
    if (scl !== 1'b1) begin
      n_bad++;
      $display("FAIL srst_scl got=%b exp=1", scl);
    end
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL srst_sda got=%b exp=1", sda);
    end
    apb_rd(BASE, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL srst_status got=%h exp=0", d);
    end
  endtask

  initial begin
    test_reset();
    test_read_fast();
    test_write_slow();
    test_addr_nack();
    test_bad_addr();
    test_hard_reset();
    test_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
